frame_fetcher: RTL
==================

FRAME_FETCHER -- requirements
Module: frame_fetcher

Interface
REQ-001 Parameter WORDS_PER_FRAME, default 64, words per frame (power of two, 2..256).
REQ-002 Parameter DATA_WIDTH, default 32, LED word width.
REQ-003 Parameter ADDR_WIDTH, default 14, frame-memory address width.
REQ-004 clock  in  1  sole clock, all logic on posedge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 frame_num  in  8  frame index from animation_renderer.
REQ-007 mem_rd  out  1  read strobe to synchronous frame memory.
REQ-008 mem_addr  out  ADDR_WIDTH  read address.
REQ-009 mem_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd.
REQ-010 out_data  out  DATA_WIDTH  word to column shifter.
REQ-011 out_valid  out  1  out_data valid.
REQ-012 out_ready  in  1  shifter accepts word.
REQ-013 out_last  out  1  marks final word of a frame.
REQ-014 frame_loaded  out  1  front buffer holds a complete frame.

Function
REQ-015 Two WORDS_PER_FRAME x DATA_WIDTH buffers: front streams out, back is filled; swap is atomic, single cycle.
REQ-016 Fetch FSM states: IDLE, FETCH, WAIT_SWAP.
REQ-017 IDLE -> FETCH when frame_num != req_frame (last requested index) or after reset; req_frame latched on entry.
REQ-018 FETCH issues one mem_rd per cycle, idx 0..WORDS_PER_FRAME-1, mem_addr = req_frame*WORDS_PER_FRAME + idx, truncated to ADDR_WIDTH.
REQ-019 Returned word written to back[idx delayed 1 cycle]; FETCH -> WAIT_SWAP when the last word is written (WORDS_PER_FRAME+1 cycles after entry).
REQ-020 frame_num change during FETCH aborts it: restart at idx 0 with new req_frame next cycle; in-flight word discarded.
REQ-021 WAIT_SWAP: swap at a frame boundary (cycle of out_last handshake, or any cycle while frame_loaded=0), then -> IDLE; frame_loaded set at first swap.
REQ-022 frame_num change during WAIT_SWAP: discard back buffer, -> FETCH with new index.
REQ-023 Output: when frame_loaded=1, out_valid=1 continuously, words front[0..WORDS_PER_FRAME-1] in order, repeating until a swap; word advances only on out_valid & out_ready.
REQ-024 out_data/out_last stable while out_valid & ~out_ready; out_last=1 exactly on word WORDS_PER_FRAME-1.
REQ-025 After swap, next output word is front[0] of the new frame; no partial frames ever emitted.

Reset
REQ-026 reset_n=0 at posedge: FSM IDLE, idx 0, out word index 0, req_frame forced to a value differing from frame_num so a fetch starts the cycle after release.
REQ-027 Reset values: mem_rd 0, mem_addr 0, out_valid 0, out_last 0, frame_loaded 0, out_data 0; buffer contents undefined, never emitted.
REQ-028 Reset mid-fetch or mid-stream abandons all work; no memory read issued while reset_n=0.

Configuration
REQ-029 Macro FRAME_FETCH_STATS_EN: when defined, output port dropped_cnt (16 bit) counts aborts from REQ-020/REQ-022, saturating at 16'hFFFF, reset 0.
REQ-030 Without FRAME_FETCH_STATS_EN: port and counter absent; all other behaviour identical.

Structure
REQ-031 Shared package holds fetch-FSM state encoding and FB_SIZE-related constants used alongside animation_renderer.
REQ-032 One sub-module: frame_buffer_pp (ping-pong dual buffer with swap input and one write/one read port).

Verification
REQ-033 Reset release, frame_num=3, WORDS=64, mem returns addr: mem_addr 192..255 over 64 cycles; frame_loaded rises; out stream 192..255 with out_last on 255.
REQ-034 out_ready toggled 1/0 each cycle: each word held on stall, no loss, 64 handshakes per frame, repeats frame until change.
REQ-035 frame_num 3->4 mid-stream of word 10: back filled with 256..319, first new word emitted only after out_last of frame 3.
REQ-036 frame_num 4->5 at fetch idx 20: fetch restarts at address 320; frame 4 data never emitted; dropped_cnt increments by 1 (macro on).
REQ-037 reset_n pulsed low at fetch idx 30: mem_rd 0 during reset, out_valid 0, full refetch from idx 0 after release.
REQ-038 frame_num=255, ADDR_WIDTH=14: mem_addr = 16320..16383 (no overflow); ADDR_WIDTH=12 wraps to low 12 bits.

Source files
------------

// File: rtl/frame_fetcher_pkg.sv
// frame_fetcher_pkg: fetch FSM encoding and frame-buffer sizing shared with animation_renderer.
package frame_fetcher_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_SWAP} fetch_state_e;

    localparam int FB_WORDS      = 64;
    localparam int FB_DATA_WIDTH = 32;
    localparam int FB_ADDR_WIDTH = 14;
    localparam int FB_FRAMES     = 256;

    function automatic logic [31:0] frame_base(input logic [7:0] f, input int unsigned words);
        return 32'(f) * words;
    endfunction

endpackage

// File: rtl/frame_buffer_pp.sv
// frame_buffer_pp: ping-pong frame store; writes land in the back half, reads come from the front half.
module frame_buffer_pp
    import frame_fetcher_pkg::*;
#(
    parameter int WORDS = FB_WORDS,
    parameter int DW    = FB_DATA_WIDTH,
    parameter int IW    = $clog2(WORDS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          swap,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic          front_q;
    logic [DW-1:0] buf_q [2][WORDS];

    always_ff @(posedge clock) begin
        if (!reset_n) front_q <= 1'b0;
        else if (swap) front_q <= ~front_q;
    end

    always_ff @(posedge clock) begin
        if (we) buf_q[~front_q][waddr] <= wdata;
    end

    assign rdata = buf_q[front_q][raddr];

endmodule

// File: rtl/frame_fetcher.sv
// frame_fetcher: fills a back buffer from frame memory and streams whole frames from the front buffer.
// Defining FRAME_FETCH_STATS_EN adds a saturating dropped_cnt of aborted fetches.
module frame_fetcher
    import frame_fetcher_pkg::*;
#(
    parameter int WORDS_PER_FRAME = FB_WORDS,
    parameter int DATA_WIDTH      = FB_DATA_WIDTH,
    parameter int ADDR_WIDTH      = FB_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [7:0]            frame_num,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  frame_loaded
`ifdef FRAME_FETCH_STATS_EN
    ,
    output logic [15:0]           dropped_cnt
`endif
);
    localparam int IW = $clog2(WORDS_PER_FRAME);
    localparam logic [IW-1:0] LAST = IW'(WORDS_PER_FRAME - 1);

    fetch_state_e          state_q;
    logic [7:0]            req_frame_q;
    logic [IW-1:0]         rd_idx_q, wr_idx_q, out_idx_q;
    logic                  rd_pend_q, mem_rd_q, loaded_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  chg, hs, swap, we, issue_more;

    assign chg        = frame_num != req_frame_q;
    assign hs         = loaded_q && out_ready;
    assign issue_more = mem_rd_q && (rd_idx_q != LAST);
    assign swap       = reset_n && (state_q == WAIT_SWAP) && !chg && (!loaded_q || (hs && out_idx_q == LAST));
    assign we         = reset_n && (state_q == FETCH) && !chg && rd_pend_q;

    // Any frame_num change restarts the fetch from idx 0, dropping whatever is in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_frame_q <= ~frame_num;
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
            rd_pend_q   <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
        end else if (chg) begin
            state_q     <= FETCH;
            req_frame_q <= frame_num;
            rd_idx_q    <= '0;
            rd_pend_q   <= 1'b0;
            mem_rd_q    <= 1'b1;
            mem_addr_q  <= ADDR_WIDTH'(frame_base(frame_num, WORDS_PER_FRAME));
        end else begin
            rd_pend_q <= mem_rd_q;
            wr_idx_q  <= rd_idx_q;
            mem_rd_q  <= issue_more;
            rd_idx_q  <= issue_more ? rd_idx_q + IW'(1) : rd_idx_q;
            mem_addr_q <= issue_more ? mem_addr_q + ADDR_WIDTH'(1) : mem_addr_q;
            if (state_q == FETCH && rd_pend_q && wr_idx_q == LAST) state_q <= WAIT_SWAP;
            if (swap) state_q <= IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_idx_q <= '0;
            loaded_q  <= 1'b0;
        end else begin
            if (hs) out_idx_q <= out_idx_q + IW'(1);
            if (swap) loaded_q <= 1'b1;
        end
    end

`ifdef FRAME_FETCH_STATS_EN
    logic [15:0] dropped_q;
    always_ff @(posedge clock) begin
        if (!reset_n) dropped_q <= '0;
        else if (chg && state_q != IDLE && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
    end
    assign dropped_cnt = dropped_q;
`endif

    frame_buffer_pp #(.WORDS(WORDS_PER_FRAME), .DW(DATA_WIDTH)) u_fb (
        .clock   (clock),
        .reset_n (reset_n),
        .swap    (swap),
        .we      (we),
        .waddr   (wr_idx_q),
        .wdata   (mem_data),
        .raddr   (out_idx_q),
        .rdata   (rdata)
    );

    assign mem_rd       = mem_rd_q;
    assign mem_addr     = mem_addr_q;
    assign out_valid    = loaded_q;
    assign out_data     = loaded_q ? rdata : '0;
    assign out_last     = loaded_q && (out_idx_q == LAST);
    assign frame_loaded = loaded_q;

endmodule
